// File: rtl/prescaled_updown_counter.sv
// rtl/prescaled_updown_counter.sv - prescaled up/down/bounce/hold modulo counter
// Optional sticky overflow flag: define CNT_OVF_STICKY_EN.
module prescaled_updown_counter #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] div,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
`ifdef CNT_OVF_STICKY_EN
  input  logic                  ovf_clr,
  output logic                  ovf_flag,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tick,
  output logic                  tc
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [WIDTH-1:0]      CNT_ZERO = '0;
  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  dir_q, dir_d;
  logic                  tick_q, tick_d;
  logic                  tc_q, tc_d;

  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_tc;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  assign count_inc = count_q + CNT_ONE;
  assign count_dec = count_q - CNT_ONE;

  // Result of one count step; only committed on a prescaler step edge.
  always_comb begin
    step_count = count_q;
    step_dir   = dir_q;
    step_tc    = 1'b0;
    case (mode)
      MODE_UP: begin
        step_dir = 1'b1;
        if (count_q >= limit) begin
          step_count = CNT_ZERO;
          step_tc    = 1'b1;
        end else begin
          step_count = count_inc;
        end
      end
      MODE_DOWN: begin
        step_dir = 1'b0;
        if (count_q == CNT_ZERO || count_q > limit) begin
          step_count = limit;
          step_tc    = 1'b1;
        end else begin
          step_count = count_dec;
        end
      end
      MODE_BOUNCE: begin
        // Direction turns on the step that reaches an end; sitting on an end
        // (after load, mode or limit change) bounces straight off it.
        if (count_q > limit) begin
          step_count = limit;
          step_dir   = 1'b0;
          step_tc    = 1'b1;
        end else if (dir_q) begin
          if (count_q == limit) begin
            step_count = (limit == CNT_ZERO) ? CNT_ZERO : limit - CNT_ONE;
            step_dir   = 1'b0;
            step_tc    = 1'b1;
          end else begin
            step_count = count_inc;
            if (count_inc == limit) begin
              step_dir = 1'b0;
              step_tc  = 1'b1;
            end
          end
        end else begin
          if (count_q == CNT_ZERO) begin
            step_count = (limit == CNT_ZERO) ? CNT_ZERO : CNT_ONE;
            step_dir   = 1'b1;
            step_tc    = 1'b1;
          end else begin
            step_count = count_dec;
            if (count_q == CNT_ONE) begin
              step_dir = 1'b1;
              step_tc  = 1'b1;
            end
          end
        end
      end
      default: begin
        step_count = count_q;
        step_dir   = dir_q;
        step_tc    = 1'b0;
      end
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
      presc_d = '0;
    end else if (en) begin
      if (presc_q >= div) begin
        presc_d = '0;
        tick_d  = 1'b1;
        count_d = step_count;
        dir_d   = step_dir;
        tc_d    = step_tc;
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

`ifdef CNT_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // Set dominates clear so a wrap coinciding with ovf_clr is never lost.
  always_comb begin
    ovf_d = tc_d | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb/tb_prescaled_updown_counter.sv - directed self-checking bench for prescaled_updown_counter
module tb_prescaled_updown_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [25:0] div;
  logic [3:0]  limit;
  logic        load;
  logic [3:0]  load_val;
  logic [3:0]  count;
  logic        dir;
  logic        tick;
  logic        tc;
`ifdef CNT_OVF_STICKY_EN
  logic        ovf_clr;
  logic        ovf_flag;
`endif

  int errors = 0;
  int checks = 0;

  int b_cnt [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int b_dir [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
  int b_tc  [8] = '{0, 0, 1, 0, 0, 1, 0, 0};

  prescaled_updown_counter #(.WIDTH(4), .PRESCALE_W(26)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .div      (div),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
`ifdef CNT_OVF_STICKY_EN
    .ovf_clr  (ovf_clr),
    .ovf_flag (ovf_flag),
`endif
    .count    (count),
    .dir      (dir),
    .tick     (tick),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; div = '0; limit = 4'd15;
    load = 1'b0; load_val = '0;
`ifdef CNT_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    step(); step();
    chk("reset_count", count, 0);
    chk("reset_dir", dir, 1);
    chk("reset_tick", tick, 0);
    chk("reset_tc", tc, 0);

    // Reset mid-count, asynchronously between edges
    rst = 1'b0; en = 1'b1;
    repeat (7) step();
    chk("run7_count", count, 7);
    chk("run7_tick", tick, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_dir", dir, 1);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_tc", tc, 0);
    #1 rst = 1'b0;

    // Prescale div=2, UP wrap at limit=5
    div = 26'd2; limit = 4'd5;
    for (int e = 1; e <= 18; e++) begin
      step();
      chk($sformatf("pre_tick_e%0d", e), tick, (e % 3 == 0) ? 1 : 0);
      chk($sformatf("pre_count_e%0d", e), count, (e / 3) % 6);
      chk($sformatf("pre_tc_e%0d", e), tc, (e == 18) ? 1 : 0);
    end

    // DOWN from 0 with limit 9
    div = '0; limit = 4'd9; mode = 2'b01;
    for (int e = 1; e <= 11; e++) begin
      step();
      chk($sformatf("down_count_e%0d", e), count, (e == 1 || e == 11) ? 9 : 10 - e);
      chk($sformatf("down_tc_e%0d", e), tc, (e == 1 || e == 11) ? 1 : 0);
      chk($sformatf("down_dir_e%0d", e), dir, 0);
    end
    load = 1'b1; load_val = 4'd12;
    step();
    chk("down_load_count", count, 12);
    chk("down_load_tc", tc, 0);
    load = 1'b0;
    step();
    chk("down_oob_count", count, 9);
    chk("down_oob_tc", tc, 1);

    // BOUNCE limit=3 from a fresh reset
    rst = 1'b1; #2 rst = 1'b0;
    mode = 2'b10; limit = 4'd3;
    for (int e = 0; e < 8; e++) begin
      step();
      chk($sformatf("bnc_count_%0d", e), count, b_cnt[e]);
      chk($sformatf("bnc_dir_%0d", e), dir, b_dir[e]);
      chk($sformatf("bnc_tc_%0d", e), tc, b_tc[e]);
    end
    // limit=0: count pinned at 0, tc every step, dir toggles
    limit = 4'd0;
    for (int e = 0; e < 3; e++) begin
      step();
      chk($sformatf("lim0_count_%0d", e), count, 0);
      chk($sformatf("lim0_tc_%0d", e), tc, 1);
      chk($sformatf("lim0_dir_%0d", e), dir, (e == 1) ? 1 : 0);
    end

    // Load colliding with a step edge, then en freeze and HOLD
    mode = 2'b00; limit = 4'd15; div = 26'd3;
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    repeat (3) step();
    chk("pre_collide_tick", tick, 0);
    load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    chk("collide_count", count, 7);
    chk("collide_tick", tick, 0);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("restart_tick_e%0d", e), tick, (e == 4) ? 1 : 0);
      chk($sformatf("restart_count_e%0d", e), count, (e == 4) ? 8 : 7);
    end
    en = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("freeze_tick_e%0d", e), tick, 0);
      chk($sformatf("freeze_count_e%0d", e), count, 8);
    end
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("unfreeze_tick_e%0d", e), tick, (e == 4) ? 1 : 0);
    end
    chk("unfreeze_count", count, 9);
    mode = 2'b11; div = '0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("hold_tick_e%0d", e), tick, 1);
      chk($sformatf("hold_count_e%0d", e), count, 9);
      chk($sformatf("hold_tc_e%0d", e), tc, 0);
    end

    // Lowering div below the running prescaler fires on the next edge
    mode = 2'b00; div = 26'd5;
    repeat (3) step();
    chk("div_hi_tick", tick, 0);
    div = 26'd1;
    step();
    chk("div_lower_tick", tick, 1);
    chk("div_lower_count", count, 10);

`ifdef CNT_OVF_STICKY_EN
    rst = 1'b1; #2 rst = 1'b0;
    chk("ovf_reset", ovf_flag, 0);
    mode = 2'b00; div = '0; limit = 4'd2;
    for (int e = 1; e <= 8; e++) begin
      ovf_clr = (e == 6 || e == 8) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("ovf_count_e%0d", e), count, e % 3);
      chk($sformatf("ovf_flag_e%0d", e), ovf_flag, (e >= 3 && e <= 7) ? 1 : 0);
    end
    ovf_clr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
